// File: rtl/my_if_skew_sampler_if.sv
// Bus bundle for the multi-skew sampler: observed grant bus in, four skewed views out.
interface my_if_skew_sampler_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gnt_in;
    logic             cb_event;
    logic [WIDTH-1:0] cb0_gnt;
    logic [WIDTH-1:0] cb1_gnt;
    logic [WIDTH-1:0] cb2_gnt;
    logic [WIDTH-1:0] cb3_gnt;
    logic             cb_valid;

    modport master (
        output gnt_in,
        input  cb_event, cb0_gnt, cb1_gnt, cb2_gnt, cb3_gnt, cb_valid
    );

    modport slave (
        input  gnt_in,
        output cb_event, cb0_gnt, cb1_gnt, cb2_gnt, cb3_gnt, cb_valid
    );
endinterface

// File: rtl/my_if_skew_sampler.sv
// Periodic sampling event that captures a fast-changing bus through four views
// with skews #0, #1step, SKEW2 ticks and SKEW3 ticks.
module my_if_skew_sampler #(
    parameter int WIDTH    = 4,
    parameter int PERIOD   = 20,
    parameter int PHASE    = 10,
    parameter int SKEW2    = 1,
    parameter int SKEW3    = 2,
    parameter int MAX_SKEW = 8
) (
    input  logic                clk,
    input  logic                rst,
    my_if_skew_sampler_if.slave bus
);
    localparam int CW    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    // Only as much history as the deepest configured view can reach is stored.
    localparam int DEPTH = (SKEW2 > SKEW3) ? SKEW2 : SKEW3;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] EVT  = CW'(PHASE);

    generate
        if (PERIOD < 2 || PHASE < 0 || PHASE >= PERIOD ||
            SKEW2 < 1 || SKEW2 > MAX_SKEW || SKEW3 < 1 || SKEW3 > MAX_SKEW) begin : g_param_err
            $error("my_if_skew_sampler: parameter out of range");
        end
    endgenerate

    logic [CW-1:0]               r_cnt;
    logic [DEPTH-1:0][WIDTH-1:0] r_hist;
    logic [WIDTH-1:0]            r_cb0;
    logic [WIDTH-1:0]            r_cb1;
    logic [WIDTH-1:0]            r_cb2;
    logic [WIDTH-1:0]            r_cb3;
    logic                        r_valid;
    logic                        w_event;

    assign w_event = (r_cnt == EVT);

    // r_hist[k] holds the bus value from k+1 ticks before the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_hist  <= '0;
            r_cb0   <= '0;
            r_cb1   <= '0;
            r_cb2   <= '0;
            r_cb3   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cnt     <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            r_hist[0] <= bus.gnt_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_valid <= w_event;
            if (w_event) begin
                r_cb0 <= bus.gnt_in;
                r_cb1 <= r_hist[0];
                r_cb2 <= r_hist[SKEW2-1];
                r_cb3 <= r_hist[SKEW3-1];
            end
        end
    end

    assign bus.cb_event = w_event;
    assign bus.cb0_gnt  = r_cb0;
    assign bus.cb1_gnt  = r_cb1;
    assign bus.cb2_gnt  = r_cb2;
    assign bus.cb3_gnt  = r_cb3;
    assign bus.cb_valid = r_valid;
endmodule

// File: tb/tb_my_if_skew_sampler.sv
// Bench for my_if_skew_sampler: three parameterisations share clk/rst/gnt_in and
// are compared each tick against a tick-indexed reference model.
module tb_my_if_skew_sampler;
    localparam int W = 4;
    localparam int P = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gnt = '0;
    int           n_chk  = 0;
    int           n_pass = 0;

    logic [W-1:0] gq[$];
    int           phs[3] = '{10, 1, 10};
    int           s2s[3] = '{1, 1, 3};
    int           s3s[3] = '{2, 2, 5};
    logic [17:0]  obs[3];

    always #5 clk = ~clk;

    my_if_skew_sampler_if #(.WIDTH(W)) ifa ();
    my_if_skew_sampler_if #(.WIDTH(W)) ifb ();
    my_if_skew_sampler_if #(.WIDTH(W)) ifc ();

    assign ifa.gnt_in = gnt;
    assign ifb.gnt_in = gnt;
    assign ifc.gnt_in = gnt;

    my_if_skew_sampler #(.WIDTH(W)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    my_if_skew_sampler #(.WIDTH(W), .PHASE(1)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    my_if_skew_sampler #(.WIDTH(W), .SKEW2(3), .SKEW3(5)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    assign obs[0] = {ifa.cb_event, ifa.cb_valid, ifa.cb0_gnt, ifa.cb1_gnt, ifa.cb2_gnt, ifa.cb3_gnt};
    assign obs[1] = {ifb.cb_event, ifb.cb_valid, ifb.cb0_gnt, ifb.cb1_gnt, ifb.cb2_gnt, ifb.cb3_gnt};
    assign obs[2] = {ifc.cb_event, ifc.cb_valid, ifc.cb0_gnt, ifc.cb1_gnt, ifc.cb2_gnt, ifc.cb3_gnt};

    // g[i] since the last reset; anything before tick 0 reads as zero.
    function automatic logic [W-1:0] gv(int i);
        if (i < 0 || i >= gq.size()) return '0;
        return gq[i];
    endfunction

    // Expected {event, valid, cb0, cb1, cb2, cb3} during tick t.
    function automatic logic [17:0] model(int ph, int s2, int s3, int t);
        int e;
        logic ev, vl;
        ev = ((t % P) == ph);
        vl = (t >= 1) && (((t - 1) % P) == ph);
        e  = -1;
        if (t >= 1 && (t - 1) >= ph) e = (t - 1) - (((t - 1) - ph) % P);
        if (e < 0) return {ev, vl, 16'h0};
        return {ev, vl, gv(e), gv(e - 1), gv(e - s2), gv(e - s3)};
    endfunction

    task automatic tick(input logic r, input logic [W-1:0] v);
        @(posedge clk);
        #1;
        rst = r;
        gnt = v;
        if (r) gq.delete();
        else   gq.push_back(v);
    endtask

    task automatic test_reset();
        logic [17:0] exp;
        int t;
        tick(1'b1, 4'h3);
        tick(1'b1, 4'h6);
        tick(1'b0, 4'h9);
        t = gq.size() - 1;
        for (int k = 0; k < 3; k++) begin
            exp = model(phs[k], s2s[k], s3s[k], t);
            n_chk++;
            if (obs[k] !== exp) $display("FAIL reset dut%0d tick %0d got %h exp %h", k, t, obs[k], exp);
            else n_pass++;
        end
        n_chk++;
        if (obs[0] !== 18'h0) $display("FAIL reset_zero dut0 got %h exp %h", obs[0], 18'h0);
        else n_pass++;
    endtask

    task automatic test_reference();
        logic [17:0] exp;
        logic [W-1:0] v;
        tick(1'b1, 4'h0);
        for (int t = 0; t <= 11; t++) begin
            v = W'($urandom_range(15));
            if (t == 0)  v = 4'h5;
            if (t == 1)  v = 4'h7;
            if (t == 8)  v = 4'h2;
            if (t == 9)  v = 4'h1;
            if (t == 10) v = 4'hD;
            tick(1'b0, v);
            for (int k = 0; k < 3; k++) begin
                exp = model(phs[k], s2s[k], s3s[k], t);
                n_chk++;
                if (obs[k] !== exp) $display("FAIL ref dut%0d tick %0d got %h exp %h", k, t, obs[k], exp);
                else n_pass++;
            end
            if (t == 2) begin
                n_chk++;
                if (obs[1][16:0] !== {1'b1, 16'h7550})
                    $display("FAIL empty_hist tick 2 got %h exp %h", obs[1][16:0], {1'b1, 16'h7550});
                else n_pass++;
            end
            if (t == 11) begin
                n_chk++;
                if (obs[0][16:0] !== {1'b1, 16'hD112})
                    $display("FAIL ref_values tick 11 got %h exp %h", obs[0][16:0], {1'b1, 16'hD112});
                else n_pass++;
            end
        end
    endtask

    task automatic test_ramp();
        logic [17:0] exp;
        tick(1'b1, 4'h0);
        for (int t = 0; t <= 32; t++) begin
            tick(1'b0, W'(t));
            for (int k = 0; k < 3; k++) begin
                exp = model(phs[k], s2s[k], s3s[k], t);
                n_chk++;
                if (obs[k] !== exp) $display("FAIL ramp dut%0d tick %0d got %h exp %h", k, t, obs[k], exp);
                else n_pass++;
            end
            if (t == 11) begin
                n_chk++;
                if (obs[0][16:0] !== {1'b1, 16'hA998})
                    $display("FAIL ramp_t11 got %h exp %h", obs[0][16:0], {1'b1, 16'hA998});
                else n_pass++;
                n_chk++;
                if (obs[2][7:0] !== 8'h75)
                    $display("FAIL skew_sweep got %h exp %h", obs[2][7:0], 8'h75);
                else n_pass++;
            end
            if (t == 31) begin
                n_chk++;
                if (obs[0][16:0] !== {1'b1, 16'hEDDC})
                    $display("FAIL ramp_t31 got %h exp %h", obs[0][16:0], {1'b1, 16'hEDDC});
                else n_pass++;
            end
            n_chk++;
            if (obs[0][16] !== (t == 11 || t == 31))
                $display("FAIL ramp_valid tick %0d got %b exp %b", t, obs[0][16], (t == 11 || t == 31));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [17:0] exp;
        logic [15:0] held;
        tick(1'b1, 4'h0);
        held = '0;
        for (int t = 0; t <= 29; t++) begin
            tick(1'b0, W'($urandom_range(15)));
            for (int k = 0; k < 3; k++) begin
                exp = model(phs[k], s2s[k], s3s[k], t);
                n_chk++;
                if (obs[k] !== exp) $display("FAIL hold dut%0d tick %0d got %h exp %h", k, t, obs[k], exp);
                else n_pass++;
            end
            if (t == 11) held = {gv(10), gv(9), gv(9), gv(8)};
            if (t > 11) begin
                n_chk++;
                if (obs[0][16:0] !== {1'b0, held})
                    $display("FAIL hold_stable tick %0d got %h exp %h", t, obs[0][16:0], {1'b0, held});
                else n_pass++;
            end
        end
    endtask

    task automatic test_midreset();
        logic [17:0] exp;
        // 0: rst at tick 15, 1: rst in the cb_valid tick, 2: rst on the event tick
        for (int sc = 0; sc < 3; sc++) begin
            tick(1'b1, 4'h0);
            for (int t = 0; t < ((sc == 0) ? 15 : (sc == 1) ? 11 : 10); t++) begin
                tick(1'b0, W'($urandom_range(15)));
                for (int k = 0; k < 3; k++) begin
                    exp = model(phs[k], s2s[k], s3s[k], t);
                    n_chk++;
                    if (obs[k] !== exp) $display("FAIL midrst%0d dut%0d tick %0d got %h exp %h", sc, k, t, obs[k], exp);
                    else n_pass++;
                end
            end
            tick(1'b1, W'($urandom_range(15)));
            for (int t = 0; t <= 11; t++) begin
                tick(1'b0, W'($urandom_range(15)));
                for (int k = 0; k < 3; k++) begin
                    exp = model(phs[k], s2s[k], s3s[k], t);
                    n_chk++;
                    if (obs[k] !== exp) $display("FAIL postrst%0d dut%0d tick %0d got %h exp %h", sc, k, t, obs[k], exp);
                    else n_pass++;
                end
                if (t == 0) begin
                    n_chk++;
                    if (obs[0] !== 18'h0) $display("FAIL rst_clear%0d got %h exp %h", sc, obs[0], 18'h0);
                    else n_pass++;
                end
                if (t == 10) begin
                    n_chk++;
                    if (obs[0][17] !== 1'b1) $display("FAIL restart_event%0d got %b exp %b", sc, obs[0][17], 1'b1);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reference();
        test_ramp();
        test_hold();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
